enemy_fleet_ctl: RTL and testbench

Motion and hit controller for the enemy wave: a row of `N_ENEMY` invaders that marches horizontally, steps down at the screen edges, and loses members when the player missile hits them. It sits directly upstream of the enemy drawing stage in the pixel pipeline, in the same way `position_rect_ctl` feeds the ship drawer. It consumes the missile position and enable produced by the missile controller, and returns a hit pulse so that controller can retire the missile. It also produces the score and wave counters for the character overlay.

---
 rtl/enemy_fleet_ctl.sv | 210 +++++++++++++++++++++
 tb/tb_enemy_fleet_ctl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/enemy_fleet_ctl.sv
`timescale 1ns/1ps
// enemy_fleet_ctl
// Motion and hit controller for one row of invaders.
//   pclk        pixel clock
//   rst         asynchronous active-low reset
//   frame_tick  one-cycle pulse per frame
//   missile_on  player missile in flight
//   missile_x/y missile tip coordinates
//   xpos/ypos   fleet origin (top-left of enemy 0)
//   alive       bit i set while enemy i is alive
//   hit         one-cycle pulse when an enemy is destroyed
//   score       destroyed-enemy count, saturating
//   wave        completed waves, wrapping
//   wave_clear  high while waiting for the next wave
//   game_over   high once the fleet has reached the bottom limit (sticky)
module enemy_fleet_ctl #(
    parameter int N_ENEMY         = 8,
    parameter int ENEMY_W         = 48,
    parameter int ENEMY_H         = 32,
    parameter int SPACING         = 96,
    parameter int X_START         = 64,
    parameter int Y_START         = 64,
    parameter int X_MIN           = 0,
    parameter int X_MAX           = 1023,
    parameter int STEP_X          = 4,
    parameter int STEP_Y          = 16,
    parameter int FRAMES_PER_STEP = 2,
    parameter int Y_LIMIT         = 640,
    parameter int WAVE_DELAY      = 60
) (
    input  logic               pclk,
    input  logic               rst,
    input  logic               frame_tick,
    input  logic               missile_on,
    input  logic [11:0]        missile_x,
    input  logic [11:0]        missile_y,
    output logic [11:0]        xpos,
    output logic [11:0]        ypos,
    output logic [N_ENEMY-1:0] alive,
    output logic               hit,
    output logic [15:0]        score,
    output logic [7:0]         wave,
    output logic               wave_clear,
    output logic               game_over
);

    typedef enum logic [1:0] {ST_RUN, ST_CLEAR, ST_OVER} state_t;

    localparam int DIV_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
    localparam int DLY_W = (WAVE_DELAY > 1) ? $clog2(WAVE_DELAY) : 1;
    // Offset from the fleet origin to the right-most pixel of the full row.
    localparam logic [12:0] ROW_SPAN = 13'((N_ENEMY - 1) * SPACING + ENEMY_W - 1);

    state_t             state_reg, state_next;
    logic [11:0]        xpos_reg, xpos_next, ypos_reg, ypos_next;
    logic [N_ENEMY-1:0] alive_reg, alive_next;
    logic               hit_reg, hit_next;
    logic [15:0]        score_reg, score_next;
    logic [7:0]         wave_reg, wave_next;
    logic               dir_left_reg, dir_left_next;
    logic [DIV_W-1:0]   div_reg, div_next;
    logic [DLY_W-1:0]   dly_reg, dly_next;
    logic               arm_reg, arm_next;
    logic               wave_clear_reg, wave_clear_next;
    logic               game_over_reg, game_over_next;

    // Box test against the currently registered fleet position.
    logic [N_ENEMY-1:0] box_match;
    logic               y_in;
    assign y_in = ({1'b0, missile_y} >= {1'b0, ypos_reg}) &&
                  ({1'b0, missile_y} <  {1'b0, ypos_reg} + 13'(ENEMY_H));

    genvar gi;
    generate
        for (gi = 0; gi < N_ENEMY; gi++) begin : g_box
            logic [12:0] left_x;
            assign left_x = {1'b0, xpos_reg} + 13'(gi * SPACING);
            assign box_match[gi] = alive_reg[gi] && y_in &&
                                   ({1'b0, missile_x} >= left_x) &&
                                   ({1'b0, missile_x} <  left_x + 13'(ENEMY_W));
        end
    endgenerate

    // Two's-complement trick isolates the lowest matching index.
    logic [N_ENEMY-1:0] kill_mask, alive_after;
    logic               hit_now, last_kill, step_now;
    logic               edge_right, edge_left, too_low;

    assign kill_mask   = box_match & (~box_match + N_ENEMY'(1));
    assign alive_after = alive_reg & ~kill_mask;
    assign hit_now     = (state_reg == ST_RUN) && missile_on && arm_reg && (|box_match);
    assign last_kill   = hit_now && (alive_after == '0);
    assign step_now    = frame_tick && (div_reg == DIV_W'(FRAMES_PER_STEP - 1));

    assign edge_right = ({1'b0, xpos_reg} + 13'(STEP_X) + ROW_SPAN) > 13'(X_MAX);
    assign edge_left  = {1'b0, xpos_reg} < (13'(X_MIN) + 13'(STEP_X));
    assign too_low    = ({1'b0, ypos_reg} + 13'(STEP_Y) + 13'(ENEMY_H)) > 13'(Y_LIMIT);

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            state_reg      <= ST_RUN;
            xpos_reg       <= 12'(X_START);
            ypos_reg       <= 12'(Y_START);
            alive_reg      <= '1;
            hit_reg        <= 1'b0;
            score_reg      <= '0;
            wave_reg       <= '0;
            dir_left_reg   <= 1'b0;
            div_reg        <= '0;
            dly_reg        <= '0;
            arm_reg        <= 1'b1;
            wave_clear_reg <= 1'b0;
            game_over_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            xpos_reg       <= xpos_next;
            ypos_reg       <= ypos_next;
            alive_reg      <= alive_next;
            hit_reg        <= hit_next;
            score_reg      <= score_next;
            wave_reg       <= wave_next;
            dir_left_reg   <= dir_left_next;
            div_reg        <= div_next;
            dly_reg        <= dly_next;
            arm_reg        <= arm_next;
            wave_clear_reg <= wave_clear_next;
            game_over_reg  <= game_over_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        xpos_next     = xpos_reg;
        ypos_next     = ypos_reg;
        alive_next    = alive_reg;
        hit_next      = 1'b0;
        score_next    = score_reg;
        wave_next     = wave_reg;
        dir_left_next = dir_left_reg;
        div_next      = div_reg;
        dly_next      = dly_reg;
        // Re-arm whenever the missile is gone, so one missile scores once.
        arm_next      = missile_on ? arm_reg : 1'b1;

        case (state_reg)
            ST_RUN: begin
                if (frame_tick)
                    div_next = step_now ? '0 : div_reg + DIV_W'(1);

                if (hit_now) begin
                    alive_next = alive_after;
                    hit_next   = 1'b1;
                    arm_next   = 1'b0;
                    if (score_reg != 16'hFFFF)
                        score_next = score_reg + 16'd1;
                end

                if (last_kill) begin
                    // Final kill overrides any coincident step or descend.
                    state_next = ST_CLEAR;
                    dly_next   = '0;
                end else if (step_now) begin
                    if ((!dir_left_reg && edge_right) || (dir_left_reg && edge_left)) begin
                        ypos_next     = ypos_reg + 12'(STEP_Y);
                        dir_left_next = !dir_left_reg;
                        if (too_low)
                            state_next = ST_OVER;
                    end else if (dir_left_reg) begin
                        xpos_next = xpos_reg - 12'(STEP_X);
                    end else begin
                        xpos_next = xpos_reg + 12'(STEP_X);
                    end
                end
            end

            ST_CLEAR: begin
                if (frame_tick) begin
                    if (dly_reg == DLY_W'(WAVE_DELAY - 1)) begin
                        state_next    = ST_RUN;
                        alive_next    = '1;
                        xpos_next     = 12'(X_START);
                        ypos_next     = 12'(Y_START);
                        dir_left_next = 1'b0;
                        div_next      = '0;
                        wave_next     = wave_reg + 8'd1;
                    end else begin
                        dly_next = dly_reg + DLY_W'(1);
                    end
                end
            end

            default: begin
                // OVER: everything frozen until reset.
            end
        endcase

        wave_clear_next = (state_next == ST_CLEAR);
        game_over_next  = (state_next == ST_OVER);
    end

    assign xpos       = xpos_reg;
    assign ypos       = ypos_reg;
    assign alive      = alive_reg;
    assign hit        = hit_reg;
    assign score      = score_reg;
    assign wave       = wave_reg;
    assign wave_clear = wave_clear_reg;
    assign game_over  = game_over_reg;

endmodule

// File: tb/tb_enemy_fleet_ctl.sv
`timescale 1ns/1ps
module tb_enemy_fleet_ctl;

    logic pclk = 1'b0;
    always #5 pclk = ~pclk;

    // DUT 1: default parameters
    logic        rst = 1'b0, frame_tick = 1'b0, missile_on = 1'b0;
    logic [11:0] missile_x = '0, missile_y = '0;
    logic [11:0] xpos, ypos;
    logic [7:0]  alive, wave;
    logic        hit, wave_clear, game_over;
    logic [15:0] score;

    // DUT 2: low Y_LIMIT for the game-over scenario
    logic        rst2 = 1'b0, frame_tick2 = 1'b0, missile_on2 = 1'b0;
    logic [11:0] missile_x2 = '0, missile_y2 = '0;
    logic [11:0] xpos2, ypos2;
    logic [7:0]  alive2, wave2;
    logic        hit2, wave_clear2, game_over2;
    logic [15:0] score2;

    enemy_fleet_ctl dut (
        .pclk(pclk), .rst(rst), .frame_tick(frame_tick), .missile_on(missile_on),
        .missile_x(missile_x), .missile_y(missile_y), .xpos(xpos), .ypos(ypos),
        .alive(alive), .hit(hit), .score(score), .wave(wave),
        .wave_clear(wave_clear), .game_over(game_over)
    );

    enemy_fleet_ctl #(.Y_LIMIT(100)) dut2 (
        .pclk(pclk), .rst(rst2), .frame_tick(frame_tick2), .missile_on(missile_on2),
        .missile_x(missile_x2), .missile_y(missile_y2), .xpos(xpos2), .ypos(ypos2),
        .alive(alive2), .hit(hit2), .score(score2), .wave(wave2),
        .wave_clear(wave_clear2), .game_over(game_over2)
    );

    typedef struct {
        int          dut;
        string       tag;
        logic [11:0] x, y;
        logic [7:0]  alv;
        logic [15:0] scr;
        logic [7:0]  wv;
        logic        wc, go;
    } exp_t;

    typedef struct {
        logic [7:0]  alv;
        logic [15:0] scr;
    } hit_t;

    exp_t chk_q[$];
    hit_t hit_q[$];
    exp_t mon_e;
    hit_t mon_h;
    logic chk_req = 1'b0;
    int   n_cmp = 0;
    int   n_fail = 0;

    task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: state checks on request, hit checks whenever a DUT pulses hit.
    always @(negedge pclk) begin
        if (chk_req && chk_q.size() > 0) begin
            mon_e = chk_q.pop_front();
            if (mon_e.dut == 1) begin
                $display("check %s: x=%0d y=%0d alive=%h score=%0d wave=%0d wc=%b go=%b",
                         mon_e.tag, xpos, ypos, alive, score, wave, wave_clear, game_over);
                cmp({mon_e.tag, ".xpos"},  16'(xpos),       16'(mon_e.x));
                cmp({mon_e.tag, ".ypos"},  16'(ypos),       16'(mon_e.y));
                cmp({mon_e.tag, ".alive"}, 16'(alive),      16'(mon_e.alv));
                cmp({mon_e.tag, ".score"}, score,           mon_e.scr);
                cmp({mon_e.tag, ".wave"},  16'(wave),       16'(mon_e.wv));
                cmp({mon_e.tag, ".wclr"},  16'(wave_clear), 16'(mon_e.wc));
                cmp({mon_e.tag, ".over"},  16'(game_over),  16'(mon_e.go));
                cmp({mon_e.tag, ".hit"},   16'(hit),        16'd0);
            end else begin
                $display("check %s: x=%0d y=%0d alive=%h score=%0d wave=%0d wc=%b go=%b",
                         mon_e.tag, xpos2, ypos2, alive2, score2, wave2, wave_clear2, game_over2);
                cmp({mon_e.tag, ".xpos"},  16'(xpos2),       16'(mon_e.x));
                cmp({mon_e.tag, ".ypos"},  16'(ypos2),       16'(mon_e.y));
                cmp({mon_e.tag, ".alive"}, 16'(alive2),      16'(mon_e.alv));
                cmp({mon_e.tag, ".score"}, score2,           mon_e.scr);
                cmp({mon_e.tag, ".wave"},  16'(wave2),       16'(mon_e.wv));
                cmp({mon_e.tag, ".wclr"},  16'(wave_clear2), 16'(mon_e.wc));
                cmp({mon_e.tag, ".over"},  16'(game_over2),  16'(mon_e.go));
            end
        end
        if (hit) begin
            if (hit_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_hit: got hit=1 alive=%h, expected no hit", alive);
            end else begin
                mon_h = hit_q.pop_front();
                $display("hit: alive=%h score=%0d", alive, score);
                cmp("hit.alive", 16'(alive), 16'(mon_h.alv));
                cmp("hit.score", score, mon_h.scr);
            end
        end
        if (hit2) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_hit2: got hit=1, expected no hit in OVER");
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge pclk);
            #1;
        end
    endtask

    task automatic tick1(input int n);
        repeat (n) begin
            frame_tick = 1'b1; cyc(1);
            frame_tick = 1'b0; cyc(1);
        end
    endtask

    task automatic tick2(input int n);
        repeat (n) begin
            frame_tick2 = 1'b1; cyc(1);
            frame_tick2 = 1'b0; cyc(1);
        end
    endtask

    task automatic expect_st(input int d, input string tag, input int x, input int y,
                             input int alv, input int scr, input int wv, input bit wc, input bit go);
        exp_t e;
        e.dut = d; e.tag = tag; e.x = 12'(x); e.y = 12'(y); e.alv = 8'(alv);
        e.scr = 16'(scr); e.wv = 8'(wv); e.wc = wc; e.go = go;
        chk_q.push_back(e);
        chk_req = 1'b1;
        cyc(1);
        chk_req = 1'b0;
    endtask

    task automatic reset1();
        rst = 1'b0; cyc(2);
        rst = 1'b1; cyc(1);
    endtask

    // One missile shot on DUT 1, optionally coinciding with a frame tick.
    task automatic shoot(input int x, input int y, input int alv, input int scr, input bit with_tick);
        hit_t h;
        h.alv = 8'(alv); h.scr = 16'(scr);
        hit_q.push_back(h);
        missile_x = 12'(x); missile_y = 12'(y);
        missile_on = 1'b1; frame_tick = with_tick;
        cyc(1);
        frame_tick = 1'b0;
        cyc(1);
        missile_on = 1'b0;
        cyc(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] a;
        // Reset values
        cyc(2);
        rst = 1'b1;
        cyc(10);
        expect_st(1, "reset", 64, 64, 8'hFF, 0, 0, 0, 0);

        // March and descend
        tick1(120);
        expect_st(1, "march120", 304, 64, 8'hFF, 0, 0, 0, 0);
        tick1(2);
        expect_st(1, "descend122", 304, 80, 8'hFF, 0, 0, 0, 0);
        tick1(2);
        expect_st(1, "left124", 300, 80, 8'hFF, 0, 0, 0, 0);

        // Single hit, held missile, second hit
        reset1();
        hit_q.push_back('{alv: 8'hF7, scr: 16'd1});
        missile_x = 12'd362; missile_y = 12'd70; missile_on = 1'b1;
        cyc(20);
        expect_st(1, "held", 64, 64, 8'hF7, 1, 0, 0, 0);
        missile_on = 1'b0;
        cyc(2);
        shoot(170, 70, 8'hF5, 2, 1'b0);
        expect_st(1, "hit2", 64, 64, 8'hF5, 2, 0, 0, 0);

        // Wave clear
        reset1();
        for (int i = 0; i < 8; i++) begin
            a = 8'hFF << (i + 1);
            shoot(74 + 96 * i, 70, a, i + 1, 1'b0);
        end
        expect_st(1, "clear", 64, 64, 8'h00, 8, 0, 1, 0);
        tick1(59);
        expect_st(1, "clear59", 64, 64, 8'h00, 8, 0, 1, 0);
        tick1(1);
        expect_st(1, "newwave", 64, 64, 8'hFF, 8, 1, 0, 0);

        // Game over on DUT 2
        rst2 = 1'b1;
        cyc(1);
        tick2(122);
        expect_st(2, "over", 304, 80, 8'hFF, 0, 0, 0, 1);
        tick2(10);
        missile_x2 = 12'd314; missile_y2 = 12'd90; missile_on2 = 1'b1;
        cyc(5);
        missile_on2 = 1'b0;
        cyc(2);
        expect_st(2, "frozen", 304, 80, 8'hFF, 0, 0, 0, 1);

        // Simultaneous hit and step, then final kill with step
        reset1();
        for (int i = 0; i < 6; i++) begin
            a = 8'hFF << (i + 1);
            shoot(74 + 96 * i, 70, a, i + 1, 1'b0);
        end
        tick1(1);
        shoot(650, 70, 8'h80, 7, 1'b1);
        expect_st(1, "hit_step", 68, 64, 8'h80, 7, 0, 0, 0);
        tick1(1);
        shoot(750, 70, 8'h00, 8, 1'b1);
        expect_st(1, "kill_step", 68, 64, 8'h00, 8, 0, 1, 0);
        reset1();
        expect_st(1, "rst_clear", 64, 64, 8'hFF, 0, 0, 0, 0);

        cmp("hits_drained", 16'(hit_q.size()), 16'd0);
        cmp("checks_drained", 16'(chk_q.size()), 16'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
